// File: rtl/dmem_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_req_ctrl: EX/MEM data-memory request controller for req/addr_ok bus  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dmem_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_req_valid,
  input  logic        es_req_wr,
  input  logic [1:0]  es_req_size,
  input  logic [31:0] es_req_addr,
  input  logic [3:0]  es_req_wstrb,
  input  logic [31:0] es_req_wdata,
  output logic        es_req_accept,
  output logic        ms_data_ready,
  output logic [31:0] ms_rdata,
  input  logic        ms_take,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_HOLD        = 2'd1,
    S_HOLD_CANCEL = 2'd2
  } state_e;

  localparam logic [2:0] C_MAX_OC = 3'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [2:0]  oc_q, oc_d;
  logic [2:0]  cancel_cnt_q, cancel_cnt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        hold_wr_q;
  logic [1:0]  hold_size_q;
  logic [31:0] hold_addr_q;
  logic [3:0]  hold_wstrb_q;
  logic [31:0] hold_wdata_q;

  logic        w_latch;
  logic        w_hc_accept;
  logic        w_accepted;
  logic        w_live;
  logic        w_drop;
  logic [3:0]  w_oc_sum;

  always_comb begin
    state_d         = state_q;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd0;
    data_sram_addr  = 32'd0;
    data_sram_wstrb = 4'd0;
    data_sram_wdata = 32'd0;
    es_req_accept   = 1'b0;
    w_latch         = 1'b0;
    w_hc_accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_sram_req = es_req_valid && !flush && (oc_q < C_MAX_OC);
        if (data_sram_req) begin
          data_sram_wr    = es_req_wr;
          data_sram_size  = es_req_size;
          data_sram_addr  = es_req_addr;
          data_sram_wstrb = es_req_wstrb;
          data_sram_wdata = es_req_wdata;
          if (data_sram_addr_ok) begin
            es_req_accept = 1'b1;
          end else begin
            w_latch = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD, S_HOLD_CANCEL: begin
        // A raised request is frozen until the bus takes it, flush or not.
        data_sram_req   = 1'b1;
        data_sram_wr    = hold_wr_q;
        data_sram_size  = hold_size_q;
        data_sram_addr  = hold_addr_q;
        data_sram_wstrb = hold_wstrb_q;
        data_sram_wdata = hold_wdata_q;
        if (data_sram_addr_ok) begin
          state_d = S_IDLE;
          if (state_q == S_HOLD) es_req_accept = !flush;
          else                   w_hc_accept   = 1'b1;
        end else if (flush) begin
          state_d = S_HOLD_CANCEL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign w_accepted = data_sram_req && data_sram_addr_ok;
  assign w_drop     = data_sram_data_ok && (cancel_cnt_q != 3'd0);
  assign w_live     = data_sram_data_ok && (cancel_cnt_q == 3'd0);
  assign w_oc_sum   = {1'b0, oc_q} + {3'd0, w_accepted};

  always_comb begin
    if (data_sram_data_ok && (w_oc_sum == 4'd0)) oc_d = 3'd0;
    else oc_d = 3'(w_oc_sum - {3'd0, data_sram_data_ok});
    // On flush everything still in flight afterwards becomes a cancelled slot.
    if (flush) cancel_cnt_d = oc_d;
    else cancel_cnt_d = cancel_cnt_q - {2'd0, w_drop} + {2'd0, w_hc_accept};
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (flush || ms_take) begin
      buf_valid_d = 1'b0;
    end else if (w_live) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      oc_q         <= 3'd0;
      cancel_cnt_q <= 3'd0;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= 32'd0;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= 2'd0;
      hold_addr_q  <= 32'd0;
      hold_wstrb_q <= 4'd0;
      hold_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      oc_q         <= oc_d;
      cancel_cnt_q <= cancel_cnt_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      if (w_latch) begin
        hold_wr_q    <= es_req_wr;
        hold_size_q  <= es_req_size;
        hold_addr_q  <= es_req_addr;
        hold_wstrb_q <= es_req_wstrb;
        hold_wdata_q <= es_req_wdata;
      end
    end
  end

  assign ms_data_ready = !flush && (buf_valid_q || w_live);
  assign ms_rdata      = !ms_data_ready ? 32'd0 :
                         buf_valid_q    ? buf_data_q : data_sram_rdata;
  assign busy          = (oc_q != 3'd0) || (state_q != S_IDLE);

endmodule
`default_nettype wire
